// File: rtl/montador_pkg.sv
// Shared constants and helpers for the line assembler (montador_linha).
package montador_pkg;

  localparam int LARGURA_PALAVRA    = 32;
  localparam int PALAVRAS_POR_LINHA = 16;
  localparam int LARGURA_LINHA      = 512;
  localparam int NUM_ENDERECOS      = 4;

  localparam int LARGURA_CONTADOR = $clog2(PALAVRAS_POR_LINHA);
  localparam int LARGURA_ENDERECO = $clog2(NUM_ENDERECOS);
  localparam int LARGURA_MONTAGEM = LARGURA_LINHA - LARGURA_PALAVRA;

  typedef logic [LARGURA_CONTADOR-1:0] contador_t;
  typedef logic [LARGURA_ENDERECO-1:0] endereco_t;

  localparam contador_t ULTIMA_PALAVRA = contador_t'(PALAVRAS_POR_LINHA - 1);

  // Top bit of beat k inside a line; beat 0 sits in the most significant slot.
  function automatic logic [8:0] base_palavra(input contador_t k);
    return 9'(LARGURA_LINHA - 1 - LARGURA_PALAVRA * int'(k));
  endfunction

endpackage

// File: rtl/montador_linha.sv
// Assembles 16 32-bit beats into a 512-bit cache line with a 2-bit slot tag.
// Optional partial-line flush is compiled in with `define MONTADOR_FLUSH_EN.
module montador_linha
  import montador_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic [LARGURA_PALAVRA-1:0] palavra,
  input  logic                       palavra_valida,
  output logic                       palavra_pronta,
  input  logic                       flush,
  output logic [LARGURA_LINHA-1:0]   linha_cache,
  output logic [LARGURA_ENDERECO-1:0] endereco,
  output logic                       linha_valida,
  input  logic                       linha_pronta
);

  contador_t                   contador;
  logic [LARGURA_MONTAGEM-1:0] montagem;
  endereco_t                   slot;
  logic                        aceita;
  logic                        saida_livre;
  logic                        carrega;
  logic                        flush_efetivo;
  logic                        flush_pendente;
  logic [LARGURA_LINHA-1:0]    linha_nova;

  assign saida_livre    = !linha_valida || linha_pronta;
  assign palavra_pronta = !(((contador == ULTIMA_PALAVRA) || flush_pendente) && !saida_livre);
  assign aceita         = palavra_valida && palavra_pronta;

`ifdef MONTADOR_FLUSH_EN
  // A flush only matters when there is something to emit, either already
  // assembled or arriving this very cycle; it waits until the output is free.
  assign flush_efetivo = flush_pendente || (flush && ((contador != '0) || aceita));

  always_ff @(posedge clk) begin
    if (!reset) flush_pendente <= 1'b0;
    else        flush_pendente <= flush_efetivo && !carrega;
  end
`else
  logic unused_flush;
  assign unused_flush   = flush;
  assign flush_pendente = 1'b0;
  assign flush_efetivo  = 1'b0;
`endif

  assign carrega = (aceita && (contador == ULTIMA_PALAVRA)) || (flush_efetivo && saida_livre);

  // Candidate line: assembled beats plus the beat accepted now; unfilled
  // beats are zero because the assembly register is cleared on every load.
  always_comb begin
    linha_nova = {montagem, {LARGURA_PALAVRA{1'b0}}};
    if (aceita) linha_nova[base_palavra(contador) -: LARGURA_PALAVRA] = palavra;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      contador     <= '0;
      montagem     <= '0;
      slot         <= '0;
      linha_cache  <= '0;
      endereco     <= '0;
      linha_valida <= 1'b0;
    end else if (carrega) begin
      linha_cache  <= linha_nova;
      endereco     <= slot;
      slot         <= slot + 1'b1;
      linha_valida <= 1'b1;
      montagem     <= '0;
      contador     <= '0;
    end else begin
      if (linha_valida && linha_pronta) linha_valida <= 1'b0;
      if (aceita) begin
        montagem <= linha_nova[LARGURA_LINHA-1:LARGURA_PALAVRA];
        contador <= contador + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_montador_linha.sv
// Directed self-checking bench for montador_linha; flush scenarios follow
// the MONTADOR_FLUSH_EN build option.
module tb_montador_linha;

  logic         clk;
  logic         reset;
  logic [31:0]  palavra;
  logic         palavra_valida;
  logic         palavra_pronta;
  logic         flush;
  logic [511:0] linha_cache;
  logic [1:0]   endereco;
  logic         linha_valida;
  logic         linha_pronta;

  int errors = 0;
  int checks = 0;

  montador_linha dut (
    .clk            (clk),
    .reset          (reset),
    .palavra        (palavra),
    .palavra_valida (palavra_valida),
    .palavra_pronta (palavra_pronta),
    .flush          (flush),
    .linha_cache    (linha_cache),
    .endereco       (endereco),
    .linha_valida   (linha_valida),
    .linha_pronta   (linha_pronta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    reset = 1'b0;
    palavra_valida = 1'b0;
    flush = 1'b0;
    palavra = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic fl);
    palavra = d;
    palavra_valida = 1'b1;
    flush = fl;
    @(posedge clk);
    #1;
    palavra_valida = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    linha_pronta = 1'b1;
    apply_reset();
    checks++; if (linha_valida !== 1'b0) begin errors++; $display("[TB] FAIL reset_valida got=%b exp=0", linha_valida); end
    checks++; if (endereco !== 2'd0) begin errors++; $display("[TB] FAIL reset_endereco got=%0d exp=0", endereco); end
    checks++; if (linha_cache !== 512'd0) begin errors++; $display("[TB] FAIL reset_linha got=%h exp=0", linha_cache); end
    checks++; if (palavra_pronta !== 1'b1) begin errors++; $display("[TB] FAIL reset_pronta got=%b exp=1", palavra_pronta); end
  endtask

  task automatic test_line_basic();
    logic [511:0] esperado;
    esperado = '0;
    linha_pronta = 1'b1;
    apply_reset();
    for (int k = 0; k < 16; k++) begin
      esperado[511 - 32*k -: 32] = 32'(k);
      drive_beat(32'(k), 1'b0);
      if (k < 15) begin
        checks++; if (linha_valida !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_valid beat=%0d got=%b exp=0", k, linha_valida); end
      end
    end
    checks++; if (linha_valida !== 1'b1) begin errors++; $display("[TB] FAIL basic_valida got=%b exp=1", linha_valida); end
    checks++; if (linha_cache[511:480] !== 32'h0) begin errors++; $display("[TB] FAIL basic_msb got=%h exp=0", linha_cache[511:480]); end
    checks++; if (linha_cache[31:0] !== 32'hF) begin errors++; $display("[TB] FAIL basic_lsb got=%h exp=f", linha_cache[31:0]); end
    checks++; if (linha_cache !== esperado) begin errors++; $display("[TB] FAIL basic_linha got=%h exp=%h", linha_cache, esperado); end
    checks++; if (endereco !== 2'd0) begin errors++; $display("[TB] FAIL basic_endereco got=%0d exp=0", endereco); end
    @(posedge clk); #1;
    checks++; if (linha_valida !== 1'b0) begin errors++; $display("[TB] FAIL basic_consumed got=%b exp=0", linha_valida); end
  endtask

  task automatic test_five_lines();
    logic [1:0] end_esperado;
    int         linhas;
    logic       caiu;
    end_esperado = 2'd0;
    linhas = 0;
    caiu = 1'b0;
    linha_pronta = 1'b1;
    apply_reset();
    for (int l = 0; l < 5; l++) begin
      for (int k = 0; k < 16; k++) begin
        palavra = 32'(l*16 + k);
        palavra_valida = 1'b1;
        #1;
        if (palavra_pronta !== 1'b1) caiu = 1'b1;
        @(posedge clk); #1;
        if (linha_valida === 1'b1) begin
          checks++; if (endereco !== end_esperado) begin errors++; $display("[TB] FAIL five_endereco line=%0d got=%0d exp=%0d", linhas, endereco, end_esperado); end
          end_esperado = end_esperado + 2'd1;
          linhas++;
        end
      end
    end
    palavra_valida = 1'b0;
    checks++; if (linhas != 5) begin errors++; $display("[TB] FAIL five_count got=%0d exp=5", linhas); end
    checks++; if (caiu !== 1'b0) begin errors++; $display("[TB] FAIL five_pronta_drop got=%b exp=0", caiu); end
    checks++; if (linha_cache[511:480] !== 32'd64 || linha_cache[31:0] !== 32'd79) begin errors++; $display("[TB] FAIL five_last_line got=%h..%h exp=40..4f", linha_cache[511:480], linha_cache[31:0]); end
  endtask

  task automatic test_stall();
    logic [511:0] linha_a;
    logic [511:0] linha_b;
    logic         caiu;
    caiu = 1'b0;
    linha_pronta = 1'b0;
    apply_reset();
    for (int k = 0; k < 16; k++) begin
      linha_a[511 - 32*k -: 32] = 32'h100 + 32'(k);
      linha_b[511 - 32*k -: 32] = 32'h200 + 32'(k);
      drive_beat(32'h100 + 32'(k), 1'b0);
    end
    checks++; if (linha_valida !== 1'b1) begin errors++; $display("[TB] FAIL stall_a_valid got=%b exp=1", linha_valida); end
    for (int k = 0; k < 15; k++) begin
      palavra = 32'h200 + 32'(k);
      palavra_valida = 1'b1;
      #1;
      if (palavra_pronta !== 1'b1) caiu = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (caiu !== 1'b0) begin errors++; $display("[TB] FAIL stall_beats_0_14 got_drop=%b exp=0", caiu); end
    palavra = 32'h20F;
    palavra_valida = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (palavra_pronta !== 1'b0) begin errors++; $display("[TB] FAIL stall_pronta cyc=%0d got=%b exp=0", c, palavra_pronta); end
      checks++; if (linha_cache !== linha_a) begin errors++; $display("[TB] FAIL stall_hold_linha cyc=%0d got=%h exp=%h", c, linha_cache, linha_a); end
      checks++; if (endereco !== 2'd0) begin errors++; $display("[TB] FAIL stall_hold_endereco cyc=%0d got=%0d exp=0", c, endereco); end
      @(posedge clk); #1;
    end
    linha_pronta = 1'b1;
    #1;
    checks++; if (palavra_pronta !== 1'b1) begin errors++; $display("[TB] FAIL stall_release_pronta got=%b exp=1", palavra_pronta); end
    @(posedge clk); #1;
    palavra_valida = 1'b0;
    checks++; if (linha_valida !== 1'b1) begin errors++; $display("[TB] FAIL stall_b_valid got=%b exp=1", linha_valida); end
    checks++; if (linha_cache !== linha_b) begin errors++; $display("[TB] FAIL stall_b_linha got=%h exp=%h", linha_cache, linha_b); end
    checks++; if (endereco !== 2'd1) begin errors++; $display("[TB] FAIL stall_b_endereco got=%0d exp=1", endereco); end
    @(posedge clk); #1;
    checks++; if (linha_valida !== 1'b0) begin errors++; $display("[TB] FAIL stall_b_consumed got=%b exp=0", linha_valida); end
  endtask

  task automatic test_reset_mid();
    logic [511:0] esperado;
    linha_pronta = 1'b1;
    apply_reset();
    for (int k = 0; k < 7; k++) drive_beat(32'hDEAD0000 + 32'(k), 1'b0);
    apply_reset();
    checks++; if (linha_valida !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_valid got=%b exp=0", linha_valida); end
    for (int k = 0; k < 16; k++) begin
      esperado[511 - 32*k -: 32] = 32'h300 + 32'(k);
      drive_beat(32'h300 + 32'(k), 1'b0);
    end
    checks++; if (linha_cache !== esperado) begin errors++; $display("[TB] FAIL mid_clean_linha got=%h exp=%h", linha_cache, esperado); end
    checks++; if (endereco !== 2'd0) begin errors++; $display("[TB] FAIL mid_clean_endereco got=%0d exp=0", endereco); end
    linha_pronta = 1'b0;
    for (int k = 0; k < 16; k++) drive_beat(32'h400 + 32'(k), 1'b0);
    apply_reset();
    checks++; if (linha_valida !== 1'b0 || linha_cache !== 512'd0) begin errors++; $display("[TB] FAIL pending_reset valid=%b msb=%h exp=0,0", linha_valida, linha_cache[511:480]); end
    linha_pronta = 1'b1;
  endtask

`ifdef MONTADOR_FLUSH_EN
  task automatic test_flush();
    logic [511:0] esperado;
    linha_pronta = 1'b1;
    apply_reset();
    drive_beat(32'hA, 1'b0);
    drive_beat(32'hB, 1'b0);
    drive_beat(32'hC, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    esperado = '0;
    esperado[511:416] = {32'hA, 32'hB, 32'hC};
    checks++; if (linha_valida !== 1'b1) begin errors++; $display("[TB] FAIL flush_valid got=%b exp=1", linha_valida); end
    checks++; if (linha_cache !== esperado) begin errors++; $display("[TB] FAIL flush_linha got=%h exp=%h", linha_cache, esperado); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (linha_valida !== 1'b0) begin errors++; $display("[TB] FAIL flush_empty got=%b exp=0", linha_valida); end
    drive_beat(32'hD, 1'b0);
    drive_beat(32'hE, 1'b1);
    esperado = '0;
    esperado[511:448] = {32'hD, 32'hE};
    checks++; if (linha_cache !== esperado || linha_valida !== 1'b1) begin errors++; $display("[TB] FAIL flush_coincident got=%h valid=%b exp=%h", linha_cache, linha_valida, esperado); end
    checks++; if (endereco !== 2'd1) begin errors++; $display("[TB] FAIL flush_coincident_end got=%0d exp=1", endereco); end
    for (int k = 0; k < 16; k++) begin
      esperado[511 - 32*k -: 32] = 32'h500 + 32'(k);
      drive_beat(32'h500 + 32'(k), k == 15);
    end
    checks++; if (linha_cache !== esperado || endereco !== 2'd2) begin errors++; $display("[TB] FAIL flush_full got=%h end=%0d exp=%h end=2", linha_cache, endereco, esperado); end
    @(posedge clk); #1;
    checks++; if (linha_valida !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_extra got=%b exp=0", linha_valida); end
  endtask
`else
  task automatic test_flush_ignored();
    logic [511:0] esperado;
    linha_pronta = 1'b1;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      esperado[511 - 32*k -: 32] = 32'h600 + 32'(k);
      drive_beat(32'h600 + 32'(k), 1'b0);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (linha_valida !== 1'b0) begin errors++; $display("[TB] FAIL flush_ignored_valid got=%b exp=0", linha_valida); end
    for (int k = 3; k < 16; k++) begin
      esperado[511 - 32*k -: 32] = 32'h600 + 32'(k);
      drive_beat(32'h600 + 32'(k), 1'b0);
    end
    checks++; if (linha_cache !== esperado || linha_valida !== 1'b1) begin errors++; $display("[TB] FAIL flush_ignored_linha got=%h exp=%h", linha_cache, esperado); end
  endtask
`endif

  initial begin
    reset = 1'b0;
    palavra = '0;
    palavra_valida = 1'b0;
    flush = 1'b0;
    linha_pronta = 1'b1;
    test_reset();
    test_line_basic();
    test_five_lines();
    test_stall();
    test_reset_mid();
`ifdef MONTADOR_FLUSH_EN
    test_flush();
`else
    test_flush_ignored();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
